// File: rtl/vc_pkg.sv
// Shared definitions for the vc cache/qspi slice: arbiter state and side
// encodings, plus the line-tag width helper used by icache, dcache and qspi.
package vc_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_I_FILL = 3'd1;
  localparam logic [STATE_W-1:0] ST_D_PUSH = 3'd2;
  localparam logic [STATE_W-1:0] ST_D_PULL = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAP    = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = ST_IDLE,
    S_I_FILL = ST_I_FILL,
    S_D_PUSH = ST_D_PUSH,
    S_D_PULL = ST_D_PULL,
    S_GAP    = ST_GAP
  } arb_state_e;

  // Which cache owned the most recent transaction.
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  // Line tag width: address bits above the byte offset within a line.
  function automatic int unsigned tag_width(input int unsigned pa,
                                            input int unsigned line_length);
    return pa - $clog2(line_length);
  endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Transfer watchdog: counts cycles while enabled, expires on reaching limit.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clr_i       - restart the count (takes priority over en_i)
//   en_i        - count this cycle
//   limit_i     - cycles allowed before expiry
//   expire_c    - combinational: this cycle's count reaches limit_i
module mem_arb_wdog #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] limit_i,
  output logic          expire_c
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count next-state.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The owner registers the fault on this edge, limit_i cycles after entry.
  assign expire_c = en_i && !clr_i && (cnt_q == (limit_i - CW'(1)));

endmodule

// File: rtl/mem_arb.sv
// Arbitrates the single qspi line-transfer engine between icache fills and
// dcache write-back+fill pairs, steering nibble strobes to the owning cache.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   i_pull, i_tag              - icache fill request and miss tag
//   i_wstrobe                  - nibble write strobe to icache
//   d_push, d_pull             - dcache write-back / fill requests
//   d_vtag, d_tag              - dcache victim tag (push), miss tag (pull)
//   d_wstrobe, d_rstrobe       - nibble write (fill) / read (push) strobes to dcache
//   i_busy, d_busy             - named cache currently owns qspi
//   q_req, q_i_d, q_write,
//   q_mem, q_tag               - registered transfer command to qspi
//   q_wstrobe, q_rstrobe,
//   q_done                     - qspi nibble strobes and completion pulse
//   fault                      - one-cycle pulse when a transfer hangs
module mem_arb
  import vc_pkg::*;
#(
  parameter int unsigned PA          = 22,
  parameter int unsigned LINE_LENGTH = 4,
  parameter logic [7:0]  RAM_PREFIX  = 8'hFF,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   i_pull,
  input  logic [tag_width(PA, LINE_LENGTH)-1:0]  i_tag,
  output logic                                   i_wstrobe,
  input  logic                                   d_push,
  input  logic                                   d_pull,
  input  logic [tag_width(PA, LINE_LENGTH)-1:0]  d_vtag,
  input  logic [tag_width(PA, LINE_LENGTH)-1:0]  d_tag,
  output logic                                   d_wstrobe,
  output logic                                   d_rstrobe,
  output logic                                   i_busy,
  output logic                                   d_busy,
  output logic                                   q_req,
  output logic                                   q_i_d,
  output logic                                   q_write,
  output logic                                   q_mem,
  output logic [tag_width(PA, LINE_LENGTH)-1:0]  q_tag,
  input  logic                                   q_wstrobe,
  input  logic                                   q_rstrobe,
  input  logic                                   q_done,
  output logic                                   fault
);

  localparam int unsigned TW = tag_width(PA, LINE_LENGTH);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  // Top address byte of a tag selects the RAM chip.
  function automatic logic is_ram(input logic [TW-1:0] tag);
    return tag[TW-1 -: 8] == RAM_PREFIX;
  endfunction

  arb_state_e    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          q_req_q, q_req_d;
  logic          q_i_d_q, q_i_d_d;
  logic          q_write_q, q_write_d;
  logic          q_mem_q, q_mem_d;
  logic [TW-1:0] q_tag_q, q_tag_d;
  logic          i_busy_q, i_busy_d;
  logic          d_busy_q, d_busy_d;
  logic          fault_d, fault_q;
  logic          wd_clr;
  logic          wd_expire;
  logic          end_xfer;
  logic          i_req, d_req;

  assign i_req = i_pull;
  assign d_req = d_push || d_pull;

  mem_arb_wdog #(.CW(CW)) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (wd_clr),
    .en_i     (q_req_q),
    .limit_i  (CW'(TIMEOUT)),
    .expire_c (wd_expire)
  );

  // Arbitration, transfer sequencing and command register next-state.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    q_req_d      = q_req_q;
    q_i_d_d      = q_i_d_q;
    q_write_d    = q_write_q;
    q_mem_d      = q_mem_q;
    q_tag_d      = q_tag_q;
    i_busy_d     = i_busy_q;
    d_busy_d     = d_busy_q;
    fault_d      = 1'b0;
    wd_clr       = 1'b0;
    end_xfer     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // On a tie the side that did not go last wins.
        if (i_req && (!d_req || (last_grant_q == SIDE_D))) begin
          state_d   = S_I_FILL;
          q_req_d   = 1'b1;
          q_i_d_d   = 1'b1;
          q_write_d = 1'b0;
          q_tag_d   = i_tag;
          q_mem_d   = is_ram(i_tag);
          i_busy_d  = 1'b1;
          wd_clr    = 1'b1;
        end else if (d_req) begin
          q_req_d  = 1'b1;
          q_i_d_d  = 1'b0;
          d_busy_d = 1'b1;
          wd_clr   = 1'b1;
          if (d_push) begin
            state_d   = S_D_PUSH;
            q_write_d = 1'b1;
            q_tag_d   = d_vtag;
            q_mem_d   = is_ram(d_vtag);
          end else begin
            state_d   = S_D_PULL;
            q_write_d = 1'b0;
            q_tag_d   = d_tag;
            q_mem_d   = is_ram(d_tag);
          end
        end
      end
      S_I_FILL, S_D_PULL: begin
        if (q_done) begin
          end_xfer = 1'b1;
        end else if (wd_expire) begin
          end_xfer = 1'b1;
          fault_d  = 1'b1;
        end
      end
      S_D_PUSH: begin
        // Fill follows the write-back directly unless the pull was withdrawn.
        if (q_done && d_pull) begin
          state_d   = S_D_PULL;
          q_write_d = 1'b0;
          q_tag_d   = d_tag;
          q_mem_d   = is_ram(d_tag);
          wd_clr    = 1'b1;
        end else if (q_done) begin
          end_xfer = 1'b1;
        end else if (wd_expire) begin
          end_xfer = 1'b1;
          fault_d  = 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (end_xfer) begin
      state_d      = S_GAP;
      q_req_d      = 1'b0;
      i_busy_d     = 1'b0;
      d_busy_d     = 1'b0;
      last_grant_d = (state_q == S_I_FILL) ? SIDE_I : SIDE_D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= SIDE_I;
      q_req_q      <= 1'b0;
      q_i_d_q      <= 1'b0;
      q_write_q    <= 1'b0;
      q_mem_q      <= 1'b0;
      q_tag_q      <= '0;
      i_busy_q     <= 1'b0;
      d_busy_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      q_req_q      <= q_req_d;
      q_i_d_q      <= q_i_d_d;
      q_write_q    <= q_write_d;
      q_mem_q      <= q_mem_d;
      q_tag_q      <= q_tag_d;
      i_busy_q     <= i_busy_d;
      d_busy_q     <= d_busy_d;
      fault_q      <= fault_d;
    end
  end

  assign q_req   = q_req_q;
  assign q_i_d   = q_i_d_q;
  assign q_write = q_write_q;
  assign q_mem   = q_mem_q;
  assign q_tag   = q_tag_q;
  assign i_busy  = i_busy_q;
  assign d_busy  = d_busy_q;
  assign fault   = fault_q;

  // Strobes pass straight through to the owner; in IDLE/GAP they are dropped.
  assign i_wstrobe = (state_q == S_I_FILL) && q_wstrobe;
  assign d_rstrobe = (state_q == S_D_PUSH) && q_rstrobe;
  assign d_wstrobe = (state_q == S_D_PULL) && q_wstrobe;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: table of per-cycle vectors plus hand sequences
// for watchdog expiry, done/timeout collision and asynchronous reset.
module tb_mem_arb;
  import vc_pkg::*;

  localparam int unsigned PA      = 22;
  localparam int unsigned LL      = 4;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned TW      = tag_width(PA, LL);
  localparam int unsigned OW      = TW + 10;

  localparam logic [TW-1:0] ITAG  = 20'h01234;
  localparam logic [TW-1:0] VTAG  = 20'hFF001;
  localparam logic [TW-1:0] DTAG  = 20'hFF002;
  localparam logic [TW-1:0] DTAG2 = 20'h00AB0;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pull, d_push, d_pull;
  logic [TW-1:0] i_tag, d_vtag, d_tag, q_tag;
  logic          i_wstrobe, d_wstrobe, d_rstrobe, i_busy, d_busy;
  logic          q_req, q_i_d, q_write, q_mem;
  logic          q_wstrobe, q_rstrobe, q_done, fault;

  int n_vec = 0;
  int n_err = 0;

  mem_arb #(.PA(PA), .LINE_LENGTH(LL), .RAM_PREFIX(8'hFF), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_pull(i_pull), .i_tag(i_tag), .i_wstrobe(i_wstrobe),
    .d_push(d_push), .d_pull(d_pull), .d_vtag(d_vtag), .d_tag(d_tag),
    .d_wstrobe(d_wstrobe), .d_rstrobe(d_rstrobe),
    .i_busy(i_busy), .d_busy(d_busy),
    .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write), .q_mem(q_mem), .q_tag(q_tag),
    .q_wstrobe(q_wstrobe), .q_rstrobe(q_rstrobe), .q_done(q_done), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [5:0]    in;   // {i_pull, d_push, d_pull, q_wstrobe, q_rstrobe, q_done}
    logic [TW-1:0] dt;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic logic [OW-1:0] ob(input logic req, iid, wr, mem, input logic [TW-1:0] tag,
                                       input logic ib, db, iws, dws, drs, flt);
    return {req, iid, wr, mem, tag, ib, db, iws, dws, drs, flt};
  endfunction

  function automatic logic [OW-1:0] e_idle();
    return '0;
  endfunction

  function automatic logic [OW-1:0] e_i(input logic iws);
    return ob(1'b1, 1'b1, 1'b0, 1'b0, ITAG, 1'b1, 1'b0, iws, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [OW-1:0] e_push(input logic drs);
    return ob(1'b1, 1'b0, 1'b1, 1'b1, VTAG, 1'b0, 1'b1, 1'b0, 1'b0, drs, 1'b0);
  endfunction

  function automatic logic [OW-1:0] e_pull(input logic [TW-1:0] tag, input logic mem, input logic dws);
    return ob(1'b1, 1'b0, 1'b0, mem, tag, 1'b0, 1'b1, 1'b0, dws, 1'b0, 1'b0);
  endfunction

  function automatic logic [OW-1:0] actual();
    return {q_req, q_i_d, q_write, q_mem, q_tag, i_busy, d_busy, i_wstrobe, d_wstrobe, d_rstrobe, fault};
  endfunction

  task automatic add(input string nm, input logic [5:0] in, input logic [TW-1:0] dt,
                     input logic [OW-1:0] e);
    vec_t v;
    v.name = nm;
    v.in   = in;
    v.dt   = dt;
    v.exp  = e;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [OW-1:0] mask;
    int            k;
    logic          early;

    reset = 1'b1;
    {i_pull, d_push, d_pull, q_wstrobe, q_rstrobe, q_done} = '0;
    i_tag = ITAG; d_vtag = VTAG; d_tag = DTAG;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("reset_outputs", actual(), '0);

    // I fill: grant latency, strobe steering, GAP suppresses stale pull.
    add("i_req_seen",  6'b100100, DTAG, e_idle());
    add("i_fill_ws1",  6'b100100, DTAG, e_i(1'b1));
    add("i_fill_ws0",  6'b100000, DTAG, e_i(1'b0));
    add("i_fill_rsx",  6'b100110, DTAG, e_i(1'b1));
    add("i_fill_ws2",  6'b100100, DTAG, e_i(1'b1));
    add("i_fill_done", 6'b100001, DTAG, e_i(1'b0));
    add("i_gap_drop",  6'b100100, DTAG, e_idle());
    add("i_idle",      6'b000000, DTAG, e_idle());
    // D push then pull, with i_pull arriving mid-push.
    add("d_req_seen",  6'b011000, DTAG, e_idle());
    add("d_push_rs",   6'b011110, DTAG, e_push(1'b1));
    add("d_push_ireq", 6'b111000, DTAG, e_push(1'b0));
    add("d_push_done", 6'b111011, DTAG, e_push(1'b1));
    add("d_pull_ws",   6'b101110, DTAG, e_pull(DTAG, 1'b1, 1'b1));
    add("d_pull_done", 6'b101001, DTAG, e_pull(DTAG, 1'b1, 1'b0));
    add("d_gap",       6'b101000, DTAG, e_idle());
    add("d_idle_ireq", 6'b100000, DTAG, e_idle());
    add("i_after_d",   6'b100000, DTAG, e_i(1'b0));
    add("i_after_dn",  6'b100001, DTAG, e_i(1'b0));
    add("i_after_gap", 6'b000000, DTAG, e_idle());
    // Persistent tie: grants alternate D, I, D.
    add("tie_seen",    6'b101000, DTAG2, e_idle());
    add("tie1_d",      6'b101000, DTAG2, e_pull(DTAG2, 1'b0, 1'b0));
    add("tie1_done",   6'b101001, DTAG2, e_pull(DTAG2, 1'b0, 1'b0));
    add("tie1_gap",    6'b101000, DTAG2, e_idle());
    add("tie1_idle",   6'b101000, DTAG2, e_idle());
    add("tie2_i",      6'b101000, DTAG2, e_i(1'b0));
    add("tie2_done",   6'b101001, DTAG2, e_i(1'b0));
    add("tie2_gap",    6'b101000, DTAG2, e_idle());
    add("tie2_idle",   6'b101000, DTAG2, e_idle());
    add("tie3_d_done", 6'b000001, DTAG2, e_pull(DTAG2, 1'b0, 1'b0));
    add("tie3_gap",    6'b000000, DTAG2, e_idle());
    add("tie3_idle",   6'b000000, DTAG2, e_idle());
    // Withdrawn i_pull: transfer still completes, nothing reissued.
    add("wd_req",      6'b100000, DTAG2, e_idle());
    add("wd_drop",     6'b000000, DTAG2, e_i(1'b0));
    add("wd_strobe",   6'b000100, DTAG2, e_i(1'b1));
    add("wd_done",     6'b000001, DTAG2, e_i(1'b0));
    add("wd_gap",      6'b000000, DTAG2, e_idle());
    add("wd_idle1",    6'b000000, DTAG2, e_idle());
    add("wd_idle2",    6'b000000, DTAG2, e_idle());

    foreach (tv[i]) begin
      tick();
      {i_pull, d_push, d_pull, q_wstrobe, q_rstrobe, q_done} = tv[i].in;
      d_tag = tv[i].dt;
      #1;
      // Command fields are only meaningful while a request is up.
      mask = '1;
      if (!tv[i].exp[OW-1]) mask[OW-2:6] = '0;
      chk(tv[i].name, actual() & mask, tv[i].exp & mask);
    end

    // Watchdog: fault exactly TIMEOUT cycles after q_req rises.
    tick(); {i_pull, d_push, d_pull, q_wstrobe, q_rstrobe, q_done} = 6'b100000;
    tick(); i_pull = 1'b0;
    chk("to_qreq_rise", OW'(q_req), OW'(1));
    k = 0;
    for (int c = 1; c <= int'(TIMEOUT) + 8; c++) begin
      tick();
      if (fault) begin
        k = c;
        break;
      end
    end
    chk("to_latency", OW'(k), OW'(TIMEOUT));
    chk("to_qreq_drop", OW'({q_req, i_busy}), OW'(0));
    tick();
    chk("to_fault_pulse", OW'({fault, q_req}), OW'(0));
    tick();
    chk("to_idle", actual() & OW'(32'h3F) , OW'(0));

    // q_done on the expiry cycle: done wins, no fault.
    i_pull = 1'b1;
    tick(); i_pull = 1'b0;
    chk("dw_qreq_rise", OW'(q_req), OW'(1));
    early = 1'b0;
    for (int c = 1; c < int'(TIMEOUT); c++) begin
      tick();
      if (fault || !q_req) early = 1'b1;
    end
    chk("dw_no_early_end", OW'(early), OW'(0));
    q_done = 1'b1;
    tick(); q_done = 1'b0;
    chk("dw_done_wins", OW'({fault, q_req, i_busy}), OW'(0));
    tick(); tick();

    // Complete a D fill so last grant is D, then reset mid-push.
    d_pull = 1'b1; d_tag = DTAG2;
    tick(); d_pull = 1'b0; q_done = 1'b1;
    chk("rs_pull_grant", OW'({q_req, d_busy}), OW'(2'b11));
    tick(); q_done = 1'b0;
    tick(); d_push = 1'b1;
    tick();
    chk("rs_push_entry", OW'({q_req, q_write, q_mem, d_busy}), OW'(4'b1111));
    q_rstrobe = 1'b1;
    #1 chk("rs_push_rstrobe", OW'(d_rstrobe), OW'(1));
    #1 reset = 1'b1;
    #1 chk("rs_async_clear", OW'({q_req, d_busy, d_rstrobe, q_write, q_mem}), OW'(0));
    #1 reset = 1'b0;
    d_push = 1'b0; q_rstrobe = 1'b0; i_pull = 1'b1; d_pull = 1'b1;
    tick();
    chk("rs_first_tie_d", OW'({q_req, q_i_d, i_busy, d_busy}), OW'(4'b1001));
    i_pull = 1'b0; d_pull = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
